// File: rtl/slv_guard_rst_ctrl_if.sv
// Signal bundle between the subordinate-guard reset controller and its environment.
// rst_req_i and slv_rst_ack_i are levels sampled every clock; rst_clear_o is a one-cycle pulse.
interface slv_guard_rst_ctrl_if #(
  parameter int CntWidth = 8
);
  logic                ena_i;
  logic                rst_req_i;
  logic                slv_rst_ack_i;
  logic                isolate_o;
  logic                slv_rst_o;
  logic                rst_clear_o;
  logic                busy_o;
  logic                fail_o;
  logic [1:0]          retry_o;
  logic [CntWidth-1:0] evt_cnt_o;
  logic [2:0]          state_o;

  // Environment side: guard request, enable and subordinate ack.
  modport master (
    output ena_i, rst_req_i, slv_rst_ack_i,
    input  isolate_o, slv_rst_o, rst_clear_o, busy_o, fail_o, retry_o, evt_cnt_o, state_o
  );

  // Controller side.
  modport slave (
    input  ena_i, rst_req_i, slv_rst_ack_i,
    output isolate_o, slv_rst_o, rst_clear_o, busy_o, fail_o, retry_o, evt_cnt_o, state_o
  );
endinterface

// File: rtl/slv_guard_rst_ctrl.sv
// Reset sequencer for a guarded subordinate: isolate -> reset -> release -> clear,
// with bounded retries on ack timeout and a sticky FAIL park state.
module slv_guard_rst_ctrl #(
  parameter int DrainCycles = 8,
  parameter int RstCycles   = 16,
  parameter int AckTimeout  = 64,
  parameter int MaxRetries  = 2,
  parameter int CntWidth    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  slv_guard_rst_ctrl_if.slave  bus
);

  if (MaxRetries > 3) begin : g_bad_max_retries
    $error("slv_guard_rst_ctrl: MaxRetries must be <= 3");
  end
  if (DrainCycles < 1 || RstCycles < 1 || AckTimeout < 1) begin : g_bad_timing
    $error("slv_guard_rst_ctrl: DrainCycles, RstCycles and AckTimeout must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISOLATE = 3'd1,
    ASSERT  = 3'd2,
    RELEASE = 3'd3,
    CLEAR   = 3'd4,
    FAIL    = 3'd5
  } state_t;

  localparam logic [CntWidth-1:0] DRAIN_LAST = CntWidth'(DrainCycles - 1);
  localparam logic [CntWidth-1:0] RST_LAST   = CntWidth'(RstCycles - 1);
  localparam logic [CntWidth-1:0] ACK_LAST   = CntWidth'(AckTimeout - 1);
  localparam logic [1:0]          MAX_RETRY  = 2'(MaxRetries);

  state_t              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [1:0]          retry_q, retry_d;
  logic [CntWidth-1:0] evt_q, evt_d;
  logic                entering_clear;

  logic isolate_q, slv_rst_q, rst_clear_q, busy_q, fail_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    case (state_q)
      IDLE: begin
        if (bus.rst_req_i && bus.ena_i) begin
          state_d = ISOLATE;
          retry_d = '0;
        end
      end
      ISOLATE: if (cnt_q == DRAIN_LAST) state_d = ASSERT;
      ASSERT:  if (cnt_q == RST_LAST) state_d = RELEASE;
      RELEASE: begin
        // An ack already high on the first RELEASE cycle is accepted as-is.
        if (bus.slv_rst_ack_i) begin
          state_d = CLEAR;
        end else if (cnt_q == ACK_LAST) begin
          if (retry_q < MAX_RETRY) begin
            state_d = ASSERT;
            retry_d = (retry_q == 2'd3) ? retry_q : retry_q + 2'd1;
          end else begin
            state_d = FAIL;
          end
        end
      end
      CLEAR:   if (!bus.rst_req_i) state_d = IDLE;
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
    // Counter restarts on every state entry and only runs in timed states.
    if (state_d != state_q || state_q == IDLE || state_q == CLEAR || state_q == FAIL) begin
      cnt_d = '0;
    end
  end

  assign entering_clear = (state_d == CLEAR) && (state_q != CLEAR);

  always_comb begin
    evt_d = evt_q;
    if (entering_clear && (evt_q != '1)) evt_d = evt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      evt_q   <= evt_d;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      isolate_q   <= 1'b0;
      slv_rst_q   <= 1'b0;
      rst_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      isolate_q   <= (state_d != IDLE);
      slv_rst_q   <= (state_d == ASSERT);
      rst_clear_q <= entering_clear;
      busy_q      <= (state_d != IDLE);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign bus.isolate_o   = isolate_q;
  assign bus.slv_rst_o   = slv_rst_q;
  assign bus.rst_clear_o = rst_clear_q;
  assign bus.busy_o      = busy_q;
  assign bus.fail_o      = fail_q;
  assign bus.retry_o     = retry_q;
  assign bus.evt_cnt_o   = evt_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl: nominal, retry, exhaustion, enable gating,
// async abort and event-counter saturation, with hand-derived cycle timelines.
module tb_slv_guard_rst_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  slv_guard_rst_ctrl_if #(.CntWidth(8)) bus ();
  slv_guard_rst_ctrl_if #(.CntWidth(2)) sbus ();

  slv_guard_rst_ctrl #(
    .DrainCycles(8), .RstCycles(16), .AckTimeout(64), .MaxRetries(2), .CntWidth(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  slv_guard_rst_ctrl #(
    .DrainCycles(2), .RstCycles(2), .AckTimeout(3), .MaxRetries(2), .CntWidth(2)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .bus(sbus)
  );

  // {isolate, slv_rst, rst_clear, busy, fail}
  function automatic logic [4:0] obs();
    return {bus.isolate_o, bus.slv_rst_o, bus.rst_clear_o, bus.busy_o, bus.fail_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Nominal timeline: request at cycle 0, ack at cycle 29, request drops at cycle 31.
  task automatic run_nominal(input string name, input bit drop_ena);
    logic [4:0] exp;
    int n;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) begin
        bus.rst_req_i = 1'b1;
        bus.ena_i     = 1'b1;
      end
      if (drop_ena && c == 12) bus.ena_i = 1'b0;
      if (c == 29) bus.slv_rst_ack_i = 1'b1;
      if (c == 31) bus.rst_req_i = 1'b0;
      step();
      n = c + 1;
      exp = {n <= 31, (n >= 9 && n <= 24), n == 30, n <= 31, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d outputs got %b expected %b", name, n, obs(), exp);
      end
    end
    bus.slv_rst_ack_i = 1'b0;
    bus.ena_i         = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs() !== 5'b0 || bus.evt_cnt_o !== 8'd0 || bus.retry_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold outputs got %b evt %0d retry %0d expected 0", obs(), bus.evt_cnt_o, bus.retry_o);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (obs() !== 5'b0 || bus.state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_release outputs got %b state %0d expected 0/0", obs(), bus.state_o);
    end
  endtask

  task automatic test_nominal();
    run_nominal("nominal", 1'b0);
    checks++;
    if (bus.evt_cnt_o !== 8'd1 || bus.retry_o !== 2'd0) begin
      errors++;
      $display("FAIL nominal_counts got evt %0d retry %0d expected 1/0", bus.evt_cnt_o, bus.retry_o);
    end
  endtask

  task automatic test_single_retry();
    logic [4:0] exp;
    int n;
    int pulses = 0;
    bus.slv_rst_ack_i = 1'b0;
    for (int c = 0; c < 115; c++) begin
      if (c == 0) begin
        bus.rst_req_i = 1'b1;
        bus.ena_i     = 1'b1;
      end
      if (c == 107) bus.slv_rst_ack_i = 1'b1;
      if (c == 108) bus.rst_req_i = 1'b0;
      step();
      n = c + 1;
      if (bus.rst_clear_o) pulses++;
      exp = {n <= 108, (n >= 9 && n <= 24) || (n >= 89 && n <= 104), n == 108, n <= 108, 1'b0};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL retry cycle %0d outputs got %b expected %b", n, obs(), exp);
      end
    end
    bus.slv_rst_ack_i = 1'b0;
    checks++;
    if (bus.retry_o !== 2'd1 || bus.evt_cnt_o !== 8'd2 || pulses != 1 || bus.fail_o !== 1'b0) begin
      errors++;
      $display("FAIL retry_counts got retry %0d evt %0d pulses %0d fail %b expected 1/2/1/0",
               bus.retry_o, bus.evt_cnt_o, pulses, bus.fail_o);
    end
  endtask

  task automatic test_enable_gating();
    bus.ena_i     = 1'b0;
    bus.rst_req_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (obs() !== 5'b0 || bus.state_o !== 3'd0) begin
        errors++;
        $display("FAIL ena_gate cycle %0d outputs got %b state %0d expected 0/0", c, obs(), bus.state_o);
      end
    end
    run_nominal("ena_drop", 1'b1);
    checks++;
    if (bus.evt_cnt_o !== 8'd3 || bus.retry_o !== 2'd0) begin
      errors++;
      $display("FAIL ena_counts got evt %0d retry %0d expected 3/0", bus.evt_cnt_o, bus.retry_o);
    end
  endtask

  task automatic test_async_reset();
    bus.rst_req_i = 1'b1;
    bus.ena_i     = 1'b1;
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (obs() !== 5'b11010) begin
      errors++;
      $display("FAIL abort_pre cycle 12 outputs got %b expected 11010", obs());
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 5'b0 || bus.evt_cnt_o !== 8'd0 || bus.retry_o !== 2'd0) begin
      errors++;
      $display("FAIL abort_async outputs got %b evt %0d retry %0d expected 0", obs(), bus.evt_cnt_o, bus.retry_o);
    end
    #2 rst = 1'b0;
    run_nominal("post_abort", 1'b0);
    checks++;
    if (bus.evt_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL post_abort_evt got %0d expected 1", bus.evt_cnt_o);
    end
  endtask

  task automatic test_exhausted();
    logic [4:0] exp;
    logic prev = 1'b0;
    int n;
    int phases = 0;
    bus.slv_rst_ack_i = 1'b0;
    for (int c = 0; c < 260; c++) begin
      if (c == 0) begin
        bus.rst_req_i = 1'b1;
        bus.ena_i     = 1'b1;
      end
      if (c == 20) bus.rst_req_i = 1'b0;
      step();
      n = c + 1;
      if (bus.slv_rst_o && !prev) phases++;
      prev = bus.slv_rst_o;
      exp = {1'b1, (n >= 9 && n <= 24) || (n >= 89 && n <= 104) || (n >= 169 && n <= 184),
             1'b0, 1'b1, n >= 249};
      checks++;
      if (obs() !== exp) begin
        errors++;
        $display("FAIL exhaust cycle %0d outputs got %b expected %b", n, obs(), exp);
      end
    end
    checks++;
    if (phases != 3 || bus.retry_o !== 2'd2 || bus.state_o !== 3'd5 || bus.evt_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL exhaust_counts got phases %0d retry %0d state %0d evt %0d expected 3/2/5/1",
               phases, bus.retry_o, bus.state_o, bus.evt_cnt_o);
    end
    for (int c = 0; c < 12; c++) begin
      bus.rst_req_i = c[0];
      bus.ena_i     = c[1];
      step();
      checks++;
      if (obs() !== 5'b10011) begin
        errors++;
        $display("FAIL fail_sticky cycle %0d outputs got %b expected 10011", c, obs());
      end
    end
    bus.rst_req_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 5'b0 || bus.retry_o !== 2'd0) begin
      errors++;
      $display("FAIL fail_exit outputs got %b retry %0d expected 0", obs(), bus.retry_o);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (obs() !== 5'b0 || bus.state_o !== 3'd0) begin
      errors++;
      $display("FAIL fail_exit_idle outputs got %b state %0d expected 0/0", obs(), bus.state_o);
    end
  endtask

  // Back-to-back recoveries on the narrow instance: 7-cycle period, pulse at n%7==6.
  task automatic test_back_to_back();
    logic [1:0] exp;
    logic [7:0] exp_evt;
    int n;
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    sbus.ena_i         = 1'b1;
    sbus.slv_rst_ack_i = 1'b1;
    for (int c = 0; c < 35; c++) begin
      sbus.rst_req_i = (c % 7 != 6);
      step();
      n = c + 1;
      exp = {n % 7 != 0, n % 7 == 6};
      checks++;
      if ({sbus.isolate_o, sbus.rst_clear_o} !== exp) begin
        errors++;
        $display("FAIL b2b cycle %0d isolate/clear got %b expected %b", n, {sbus.isolate_o, sbus.rst_clear_o}, exp);
      end
      if (n % 7 == 6 && exp_q.size() > 0) begin
        exp_evt = exp_q.pop_front();
        checks++;
        if ({6'd0, sbus.evt_cnt_o} !== exp_evt) begin
          errors++;
          $display("FAIL sat_evt cycle %0d got %0d expected %0d", n, sbus.evt_cnt_o, exp_evt);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || sbus.evt_cnt_o !== 2'd3) begin
      errors++;
      $display("FAIL sat_final got evt %0d pending %0d expected 3/0", sbus.evt_cnt_o, exp_q.size());
    end
    sbus.rst_req_i = 1'b0;
  endtask

  initial begin
    bus.ena_i          = 1'b0;
    bus.rst_req_i      = 1'b0;
    bus.slv_rst_ack_i  = 1'b0;
    sbus.ena_i         = 1'b0;
    sbus.rst_req_i     = 1'b0;
    sbus.slv_rst_ack_i = 1'b0;
    test_reset();
    test_nominal();
    test_single_retry();
    test_enable_gating();
    test_async_reset();
    test_exhausted();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
